// File: rtl/ltl_report_collector.sv
// ltl_report_collector
//   Collects report-STE activity from an Automata_ltl cluster. On every cycle
//   the automaton consumes a symbol (run=1) with at least one report bit set,
//   the record {symbol offset, report bits} is queued in a circular FIFO. The
//   consumer drains the FIFO over a valid/ready interface. Records that arrive
//   while the FIFO is full and not being popped are dropped. A drop sets a
//   sticky overflow flag and increments a saturating drop counter.
//
// Ports
//   clk        : clock, all logic on posedge
//   reset_n    : asynchronous active-low reset
//   run        : symbol consumed this cycle
//   clear      : synchronous stream restart (priority over push/pop)
//   report_in  : report STE active bits
//   rec_valid  : head record available
//   rec_ready  : consumer accepts head record
//   rec_offset : symbol offset of head record (0 when empty)
//   rec_bits   : report vector of head record (0 when empty)
//   fifo_count : occupied entries, 0..DEPTH
//   overflow   : sticky, set on first dropped record
//   drop_count : dropped records, saturating
module ltl_report_collector #(
  parameter int N_REPORTS = 4,
  parameter int OFFSET_W  = 32,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       run,
  input  logic                       clear,
  input  logic [N_REPORTS-1:0]       report_in,
  output logic                       rec_valid,
  input  logic                       rec_ready,
  output logic [OFFSET_W-1:0]        rec_offset,
  output logic [N_REPORTS-1:0]       rec_bits,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  output logic [CNT_W-1:0]           drop_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_FW = PTR_W + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [OFFSET_W-1:0]  r_off;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_FW-1:0]    r_count;
  logic                 r_overflow;
  logic [CNT_W-1:0]     r_drop_cnt;
  logic [OFFSET_W-1:0]  r_mem_off  [DEPTH];
  logic [N_REPORTS-1:0] r_mem_bits [DEPTH];

  logic w_push_req;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // clear suppresses sampling of the report presented in the same cycle
  assign w_push_req = run && (|report_in) && !clear;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_FW'(DEPTH));
  assign w_pop      = !w_empty && rec_ready;
  // a full FIFO still accepts a push when the head is popped at the same edge
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_off      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clear) begin
      r_off      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (run) begin
        r_off <= r_off + OFFSET_W'(1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_FW'(1);
        2'b01:   r_count <= r_count - CNT_FW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= sat_inc(r_drop_cnt);
      end
    end
  end

  // Record storage carries data only; validity comes from r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_off[r_wr_ptr]  <= r_off;
      r_mem_bits[r_wr_ptr] <= report_in;
    end
  end

  assign rec_valid  = !w_empty;
  assign rec_offset = w_empty ? '0 : r_mem_off[r_rd_ptr];
  assign rec_bits   = w_empty ? '0 : r_mem_bits[r_rd_ptr];
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_cnt;

endmodule

// File: tb/tb_ltl_report_collector.sv
module tb_ltl_report_collector;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run, clear, rec_ready;
  logic [3:0]  report_in;
  logic        rec_valid;
  logic [31:0] rec_offset;
  logic [3:0]  rec_bits;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [15:0] drop_count;

  logic        run4, clear4, ready4;
  logic [3:0]  report4;
  logic        valid4;
  logic [3:0]  offset4;
  logic [3:0]  bits4;
  logic [3:0]  count4;
  logic        ovf4;
  logic [15:0] drops4;

  always #5 clk = ~clk;

  ltl_report_collector #(.N_REPORTS(4), .OFFSET_W(32), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .clear(clear), .report_in(report_in),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_offset(rec_offset),
    .rec_bits(rec_bits), .fifo_count(fifo_count), .overflow(overflow),
    .drop_count(drop_count)
  );

  ltl_report_collector #(.N_REPORTS(4), .OFFSET_W(4), .DEPTH(DEPTH), .CNT_W(16)) dut4 (
    .clk(clk), .reset_n(reset_n), .run(run4), .clear(clear4), .report_in(report4),
    .rec_valid(valid4), .rec_ready(ready4), .rec_offset(offset4),
    .rec_bits(bits4), .fifo_count(count4), .overflow(ovf4),
    .drop_count(drops4)
  );

  typedef struct {
    logic [31:0] off;
    logic [3:0]  bits;
  } rec_t;

  rec_t        m_q[$];
  logic [31:0] m_off;
  logic        m_ovf;
  logic [15:0] m_drops;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_off   = '0;
    m_ovf   = 1'b0;
    m_drops = '0;
  endfunction

  // One clock edge of the collector, described as queue operations.
  function automatic void model_edge();
    rec_t r;
    if (clear) begin
      model_reset();
      return;
    end
    if (m_q.size() > 0 && rec_ready) void'(m_q.pop_front());
    if (run && report_in != 4'd0) begin
      if (m_q.size() < DEPTH) begin
        r.off  = m_off;
        r.bits = report_in;
        m_q.push_back(r);
      end else begin
        m_ovf = 1'b1;
        if (m_drops != 16'hFFFF) m_drops++;
      end
    end
    if (run) m_off = m_off + 32'd1;
  endfunction

  task automatic compare_model();
    chk("valid", 64'(rec_valid), 64'(m_q.size() != 0));
    chk("offset", 64'(rec_offset), (m_q.size() != 0) ? 64'(m_q[0].off) : 64'd0);
    chk("bits", 64'(rec_bits), (m_q.size() != 0) ? 64'(m_q[0].bits) : 64'd0);
    chk("count", 64'(fifo_count), 64'(m_q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drops", 64'(drop_count), 64'(m_drops));
  endtask

  // Inputs are set by the caller after a negedge; check, take the edge, advance.
  task automatic step();
    compare_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    run = 0; clear = 0; rec_ready = 0; report_in = 4'd0;
  endtask

  task automatic do_clear();
    idle_inputs();
    clear = 1;
    step();
    clear = 0;
  endtask

  initial begin
    int runs;
    reset_n = 0;
    idle_inputs();
    run4 = 0; clear4 = 0; ready4 = 0; report4 = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(rec_valid), 64'd0);
    chk("rst_offset", 64'(rec_offset), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drops", 64'(drop_count), 64'd0);
    reset_n = 1;
    @(negedge clk);

    // basic capture: report on 3rd run cycle only
    for (int i = 0; i < 5; i++) begin
      run = 1;
      report_in = (i == 2) ? 4'b0010 : 4'd0;
      step();
      if (i == 2) chk("cap_valid_next", 64'(rec_valid), 64'd1);
    end
    idle_inputs();
    chk("cap_count", 64'(fifo_count), 64'd1);
    chk("cap_offset", 64'(rec_offset), 64'd2);
    chk("cap_bits", 64'(rec_bits), 64'b0010);
    do_clear();

    // run gating
    for (int i = 0; i < 4; i++) begin
      run = (i == 3);
      report_in = 4'hF;
      step();
    end
    idle_inputs();
    chk("gate_count", 64'(fifo_count), 64'd1);
    chk("gate_offset", 64'(rec_offset), 64'd0);
    chk("gate_bits", 64'(rec_bits), 64'hF);
    do_clear();

    // overflow: 10 reports into 8 entries
    for (int i = 0; i < 10; i++) begin
      run = 1;
      report_in = 4'($urandom_range(1, 15));
      step();
    end
    idle_inputs();
    chk("ovf_count", 64'(fifo_count), 64'd8);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drops", 64'(drop_count), 64'd2);
    rec_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain_off", 64'(rec_offset), 64'(i));
      step();
    end
    chk("ovf_empty", 64'(rec_valid), 64'd0);
    do_clear();

    // full with simultaneous pop
    for (int i = 0; i < 8; i++) begin
      run = 1;
      report_in = 4'($urandom_range(1, 15));
      step();
    end
    rec_ready = 1;
    report_in = 4'h9;
    step();
    idle_inputs();
    chk("fullpop_count", 64'(fifo_count), 64'd8);
    chk("fullpop_drops", 64'(drop_count), 64'd0);
    rec_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("fullpop_drain_off", 64'(rec_offset), 64'(i + 1));
      step();
    end
    do_clear();

    // randomized backpressure over 1000 run cycles
    runs = 0;
    while (runs < 1000) begin
      run = ($urandom_range(0, 3) != 0);
      report_in = 4'($urandom);
      rec_ready = $urandom_range(0, 1);
      if (run) runs++;
      step();
    end
    do_clear();

    // clear with queued records and overflow set
    for (int i = 0; i < 9; i++) begin
      run = 1;
      report_in = 4'h1;
      step();
    end
    run = 0;
    rec_ready = 1;
    repeat (5) step();
    chk("pre_clear_count", 64'(fifo_count), 64'd3);
    chk("pre_clear_ovf", 64'(overflow), 64'd1);
    clear = 1; run = 1; report_in = 4'h5; rec_ready = 1;
    step();
    idle_inputs();
    chk("clr_count", 64'(fifo_count), 64'd0);
    chk("clr_ovf", 64'(overflow), 64'd0);
    chk("clr_drops", 64'(drop_count), 64'd0);
    run = 1; report_in = 4'h3;
    step();
    idle_inputs();
    chk("clr_next_off", 64'(rec_offset), 64'd0);
    chk("clr_next_bits", 64'(rec_bits), 64'h3);
    run = 1; report_in = 4'h6;
    step();
    run = 0; rec_ready = 1;
    #2;
    reset_n = 0;
    #1;
    chk("arst_valid", 64'(rec_valid), 64'd0);
    chk("arst_offset", 64'(rec_offset), 64'd0);
    chk("arst_bits", 64'(rec_bits), 64'd0);
    chk("arst_count", 64'(fifo_count), 64'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1;
    idle_inputs();
    step();

    // offset wrap on a 4-bit counter, streaming push+pop each cycle
    for (int i = 0; i < 20; i++) begin
      run4 = 1; report4 = 4'h8; ready4 = 1;
      @(posedge clk);
      @(negedge clk);
      chk("w4_valid", 64'(valid4), 64'd1);
      chk("w4_offset", 64'(offset4), 64'(i % 16));
      chk("w4_count", 64'(count4), 64'd1);
    end
    run4 = 0; report4 = 4'd0; ready4 = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
